// File: rtl/tick_sched.sv
// tick_sched: clock-enable sequencer for the CPU core.
// Produces a one-cycle tick at a programmable divide rate and sequences
// halt / free-run / single-step / N-tick burst operation.
module tick_sched #(
  parameter int DIV_W     = 8,
  parameter int DEF_DIV   = 240,
  parameter int DEF_BURST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [DIV_W-1:0] cfg_wdata,
  input  logic             halt_req,
  input  logic             step_req,
  output logic             tick,
  output logic             done,
  output logic             busy,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_BURST = 2'd3
  } state_t;

  localparam logic [DIV_W:0] CNT_ONE = (DIV_W+1)'(1);
  localparam logic [DIV_W:0] CNT_TWO = (DIV_W+1)'(2);

  state_t           r_state;
  logic [DIV_W:0]   r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_burst;
  logic [DIV_W-1:0] r_rem;
  logic             r_fast;
  logic             r_tick;
  logic             r_done;
  logic             r_busy;

  state_t           w_state_nxt;
  logic [DIV_W:0]   w_cnt_nxt;
  logic [DIV_W-1:0] w_rem_nxt;
  logic             w_tick_nxt;
  logic             w_done_nxt;

  // run and burst_go act only as write events; fast is the only stored CTRL bit.
  logic w_ctrl_wr;
  logic w_run_set;
  logic w_run_clr;
  logic w_burst_go;
  logic w_due;

  assign w_ctrl_wr  = cfg_we && (cfg_addr == 2'd0);
  assign w_run_set  = w_ctrl_wr &&  cfg_wdata[0];
  assign w_run_clr  = w_ctrl_wr && !cfg_wdata[0];
  assign w_burst_go = w_ctrl_wr &&  cfg_wdata[2];
  assign w_due      = (r_cnt >= {1'b0, r_div});

  // Configuration registers; new values are seen from the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div   <= DIV_W'(DEF_DIV);
      r_burst <= DIV_W'(DEF_BURST);
      r_fast  <= 1'b0;
    end else if (cfg_we) begin
      case (cfg_addr)
        2'd0:    r_fast  <= cfg_wdata[1];
        2'd1:    r_div   <= cfg_wdata;
        2'd2:    r_burst <= cfg_wdata;
        default: ;
      endcase
    end
  end

  // Next-state, counter and output pulse decode; halt_req overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_tick_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_cnt_nxt   = '0;

    if (r_state != S_HALT) begin
      if (w_due) begin
        w_tick_nxt = 1'b1;
        w_cnt_nxt  = '0;
      end else begin
        w_cnt_nxt  = r_cnt + (r_fast ? CNT_TWO : CNT_ONE);
      end
    end

    case (r_state)
      S_HALT: begin
        if (w_run_set) begin
          w_state_nxt = S_RUN;
        end else if (w_burst_go) begin
          if (r_burst != '0) begin
            w_state_nxt = S_BURST;
            w_rem_nxt   = r_burst;
          end else begin
            w_done_nxt  = 1'b1;
          end
        end else if (step_req) begin
          w_state_nxt = S_STEP;
        end
      end
      S_RUN: begin
        if (w_run_clr) w_state_nxt = S_HALT;
      end
      S_STEP: begin
        if (w_due) begin
          w_state_nxt = S_HALT;
          w_done_nxt  = 1'b1;
        end
      end
      S_BURST: begin
        if (w_due) begin
          w_rem_nxt = r_rem - 1'b1;
          if (r_rem == DIV_W'(1)) begin
            w_state_nxt = S_HALT;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_HALT;
    endcase

    // A tick already due on this edge still goes out, but no done.
    if (halt_req) begin
      w_state_nxt = S_HALT;
      w_done_nxt  = 1'b0;
      w_rem_nxt   = '0;
    end

    // Every run/step/burst entry starts counting from zero.
    if (w_state_nxt == S_HALT) w_cnt_nxt = '0;
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_HALT;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rem   <= w_rem_nxt;
      r_tick  <= w_tick_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= (w_state_nxt != S_HALT);
    end
  end

  assign tick  = r_tick;
  assign done  = r_done;
  assign busy  = r_busy;
  assign state = r_state;

endmodule

// File: tb/tb_tick_sched.sv
// tb_tick_sched: scoreboard bench for tick_sched. Expected tick/done cycle
// numbers are queued when stimulus is applied and popped when the DUT pulses.
module tb_tick_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic       halt_req;
  logic       step_req;
  logic       tick;
  logic       done;
  logic       busy;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int exp_tick[$];
  int exp_done[$];

  tick_sched #(.DIV_W(8), .DEF_DIV(240), .DEF_BURST(1)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .halt_req(halt_req), .step_req(step_req),
    .tick(tick), .done(done), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  // Edge counter: the value seen at a negedge is the number of the last posedge.
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every pulse must match the head of its queue.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (tick === 1'b1) begin
        checks++;
        if (exp_tick.size() == 0) begin
          failures++;
          $display("FAIL tick_unexpected at edge %0d: got tick=1, required none", cyc);
        end else begin
          int e;
          e = exp_tick.pop_front();
          if (cyc !== e) begin
            failures++;
            $display("FAIL tick_time: got edge %0d, required edge %0d", cyc, e);
          end
        end
      end
      if (done === 1'b1) begin
        checks++;
        if (exp_done.size() == 0) begin
          failures++;
          $display("FAIL done_unexpected at edge %0d: got done=1, required none", cyc);
        end else begin
          int e;
          e = exp_done.pop_front();
          if (cyc !== e) begin
            failures++;
            $display("FAIL done_time: got edge %0d, required edge %0d", cyc, e);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, required finish before 2ms");
    $fatal(1, "timeout");
  end

  // Drive one config write; e returns the edge number that samples it.
  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d, output int e);
    e = cyc + 1;
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'h00;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({tick, done, busy, state} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs: got tick/done/busy/state=%b, required 00000", {tick, done, busy, state});
    end
  endtask

  task automatic test_run();
    int e, dmy;
    cfg_write(2'd1, 8'd3, dmy);
    cfg_write(2'd0, 8'h01, e);
    for (int k = 1; k <= 5; k++) exp_tick.push_back(e + 4*k);
    checks++;
    if (state !== 2'd1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL run_state: got state=%0d busy=%b, required state=1 busy=1", state, busy);
    end
    wait_until(e + 21);
    cfg_write(2'd0, 8'h00, dmy);
    repeat (10) @(negedge clk);
    checks++;
    if (exp_tick.size() != 0 || state !== 2'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL run_end: got pending=%0d state=%0d busy=%b, required 0 0 0", exp_tick.size(), state, busy);
    end
  endtask

  task automatic test_fast();
    int e, dmy;
    cfg_write(2'd1, 8'd4, dmy);
    cfg_write(2'd0, 8'h03, e);
    for (int k = 1; k <= 4; k++) exp_tick.push_back(e + 3*k);
    wait_until(e + 13);
    cfg_write(2'd0, 8'h00, dmy);
    cfg_write(2'd1, 8'd255, dmy);
    cfg_write(2'd0, 8'h03, e);
    exp_tick.push_back(e + 129);
    exp_tick.push_back(e + 258);
    wait_until(e + 258);
    cfg_write(2'd0, 8'h00, dmy);
    repeat (5) @(negedge clk);
    checks++;
    if (exp_tick.size() != 0) begin
      failures++;
      $display("FAIL fast_ticks: got %0d ticks missing, required 0", exp_tick.size());
    end
  endtask

  task automatic test_step();
    int s, dmy;
    cfg_write(2'd1, 8'd2, dmy);
    s = cyc + 1;
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    exp_tick.push_back(s + 3);
    exp_done.push_back(s + 3);
    checks++;
    if (state !== 2'd2 || busy !== 1'b1) begin
      failures++;
      $display("FAIL step_state: got state=%0d busy=%b, required state=2 busy=1", state, busy);
    end
    repeat (53) @(negedge clk);
    checks++;
    if (exp_tick.size() != 0 || exp_done.size() != 0 || state !== 2'd0) begin
      failures++;
      $display("FAIL step_end: got pending=%0d/%0d state=%0d, required 0/0 state=0",
               exp_tick.size(), exp_done.size(), state);
    end
  endtask

  task automatic test_burst();
    int e, dmy;
    cfg_write(2'd2, 8'd5, dmy);
    cfg_write(2'd1, 8'd1, dmy);
    cfg_write(2'd0, 8'h04, e);
    for (int k = 1; k <= 5; k++) exp_tick.push_back(e + 2*k);
    exp_done.push_back(e + 10);
    checks++;
    if (state !== 2'd3) begin
      failures++;
      $display("FAIL burst_state: got state=%0d, required 3", state);
    end
    wait_until(e + 40);
    checks++;
    if (exp_tick.size() != 0 || exp_done.size() != 0 || state !== 2'd0) begin
      failures++;
      $display("FAIL burst_end: got pending=%0d/%0d state=%0d, required 0/0 state=0",
               exp_tick.size(), exp_done.size(), state);
    end
    cfg_write(2'd2, 8'd0, dmy);
    exp_done.push_back(cyc + 1);
    cfg_write(2'd0, 8'h04, dmy);
    checks++;
    if (state !== 2'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL burst_zero_state: got state=%0d busy=%b, required 0 0", state, busy);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (exp_done.size() != 0) begin
      failures++;
      $display("FAIL burst_zero_done: got %0d done missing, required 0", exp_done.size());
    end
  endtask

  task automatic test_halt();
    int e, dmy;
    cfg_write(2'd1, 8'd3, dmy);
    cfg_write(2'd0, 8'h01, e);
    exp_tick.push_back(e + 4);
    exp_tick.push_back(e + 8);
    wait_until(e + 7);
    halt_req = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 2'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL halt_state: got state=%0d busy=%b, required 0 0", state, busy);
    end
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    repeat (3) @(negedge clk);
    halt_req = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (exp_tick.size() != 0 || state !== 2'd0) begin
      failures++;
      $display("FAIL halt_end: got pending=%0d state=%0d, required 0 0", exp_tick.size(), state);
    end
  endtask

  task automatic test_reset_mid_burst();
    int e, r, g, dmy;
    cfg_write(2'd2, 8'd5, dmy);
    cfg_write(2'd1, 8'd3, dmy);
    cfg_write(2'd0, 8'h04, e);
    exp_tick.push_back(e + 4);
    exp_tick.push_back(e + 8);
    wait_until(e + 9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({tick, done, busy, state} !== 5'b0 || exp_tick.size() != 0) begin
      failures++;
      $display("FAIL rst_mid_burst: got tick/done/busy/state=%b pending=%0d, required 00000 0",
               {tick, done, busy, state}, exp_tick.size());
    end
    // DIV must be back to 240: first tick 241 edges after RUN entry.
    cfg_write(2'd0, 8'h01, r);
    exp_tick.push_back(r + 241);
    wait_until(r + 242);
    cfg_write(2'd0, 8'h00, dmy);
    checks++;
    if (exp_tick.size() != 0) begin
      failures++;
      $display("FAIL rst_div_default: got %0d ticks missing, required 0", exp_tick.size());
    end
    cfg_write(2'd1, 8'd0, dmy);
    cfg_write(2'd0, 8'h01, g);
    for (int k = 1; k <= 11; k++) exp_tick.push_back(g + k);
    wait_until(g + 10);
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (exp_tick.size() != 0 || state !== 2'd0) begin
      failures++;
      $display("FAIL div0_every_cycle: got pending=%0d state=%0d, required 0 0", exp_tick.size(), state);
    end
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'h00;
    halt_req = 1'b0; step_req = 1'b0;
    @(negedge clk);
    test_reset();
    test_run();
    test_fast();
    test_step();
    test_burst();
    test_halt();
    test_reset_mid_burst();
    checks++;
    if (exp_tick.size() != 0 || exp_done.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got pending=%0d/%0d, required 0/0", exp_tick.size(), exp_done.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
